dtw_ref_pingpong: RTL

Double-buffered reference store for a multi-core DTW array. Reference samples stream from the source FIFO into the shadow bank while up to NUM_CORES DTW cores read the active bank in parallel, each through its own address port. When the shadow load completes and no read session is open, the banks swap automatically. This hides reference reload time behind DTW compute.

---
 rtl/dtw_ref_pkg.sv | 13 +
 rtl/dtw_ref_pingpong_if.sv | 12 +
 rtl/dtw_ref_bank.sv | 35 +++
 rtl/dtw_ref_pingpong.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dtw_ref_pkg.sv
// Shared constants for the DTW reference ping-pong store.
package dtw_ref_pkg;
  localparam int unsigned DEF_PTR_WIDTH = 16;
  localparam int unsigned LEN_WIDTH     = DEF_PTR_WIDTH + 1;

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_LOAD  = 2'd1;
  localparam logic [1:0] L_DRAIN = 2'd2;

  function automatic int unsigned len_width(input int unsigned ptr_w);
    return ptr_w + 1;
  endfunction
endpackage

// File: rtl/dtw_ref_pingpong_if.sv
// Source FIFO handshake between the reference store and its sample FIFO.
interface dtw_ref_pingpong_if #(parameter int WIDTH = 16);
  logic             src_fifo_rden_out;
  logic             src_fifo_clear_out;
  logic             src_fifo_empty;
  logic [WIDTH-1:0] src_fifo_data_in;

  modport master (output src_fifo_rden_out, output src_fifo_clear_out,
                  input src_fifo_empty, input src_fifo_data_in);
  modport slave  (input src_fifo_rden_out, input src_fifo_clear_out,
                  output src_fifo_empty, output src_fifo_data_in);
endinterface

// File: rtl/dtw_ref_bank.sv
// One reference bank: shared write port, one replicated RAM per read port so
// every core gets an independent registered read.
module dtw_ref_bank #(
  parameter int WIDTH     = 16,
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_we,
  input  logic [PTR_W-1:0]           i_waddr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic [NUM_CORES*PTR_W-1:0] i_raddr,
  output logic [NUM_CORES*WIDTH-1:0] o_rdata
);
  localparam int DEPTH = 1 << PTR_W;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_port
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // write port shared by all replicas
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // registered read for this core
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= '0;
      else        r_q <= r_mem[i_raddr[c*PTR_W +: PTR_W]];
    end

    assign o_rdata[c*WIDTH +: WIDTH] = r_q;
  end
endmodule

// File: rtl/dtw_ref_pingpong.sv
// Double-buffered DTW reference store: the shadow bank loads from the FIFO
// while cores read the active bank; banks swap when no read session is open.
module dtw_ref_pingpong import dtw_ref_pkg::*; #(
  parameter int WIDTH            = 16,
  parameter int NUM_CORES        = 4,
  parameter int REFMEM_PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int REF_DEPTH        = 2 ** REFMEM_PTR_WIDTH,
  localparam int LW = (REFMEM_PTR_WIDTH == DEF_PTR_WIDTH) ? LEN_WIDTH
                                                          : len_width(REFMEM_PTR_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  load_start_in,
  input  logic                                  abort_in,
  input  logic [LW-1:0]                         ref_len_in,
  input  logic                                  dtw_start_in,
  input  logic [NUM_CORES-1:0]                  dtw_done_in,
  input  logic [NUM_CORES*REFMEM_PTR_WIDTH-1:0] dtw_read_addr_in,
  output logic [NUM_CORES*WIDTH-1:0]            ref_data_out,
  dtw_ref_pingpong_if.master                    src_fifo,
  output logic                                  busy_out,
  output logic                                  load_busy_out,
  output logic                                  read_busy_out,
  output logic                                  active_valid_out,
  output logic                                  shadow_valid_out,
  output logic                                  active_bank_out,
  output logic [LW-1:0]                         active_len_out,
  output logic                                  err_out,
  output logic [1:0]                            dbg_load_state_out,
  output logic [REFMEM_PTR_WIDTH-1:0]           dbg_wr_addr_out
);
  localparam logic [LW-1:0] DEPTH_L = LW'(REF_DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  logic [1:0]           r_state;
  logic [LW-1:0]        r_len, r_issue, r_wr_ptr, r_active_len, r_shadow_len;
  logic                 r_rd_valid, r_shadow_valid, r_active_valid, r_active_bank;
  logic                 r_read_busy, r_err, r_clear, r_rd_sel;
  logic [NUM_CORES-1:0] r_done_mask;

  logic w_rden, w_len_ok, w_load_acc, w_abort, w_wr_en, w_last_wr;
  logic w_swap, w_start_acc;
  logic [NUM_CORES-1:0] w_mask_next;
  logic [NUM_CORES*WIDTH-1:0] w_rdata0, w_rdata1;

  // command decode; abort wins over a coincident final write
  always_comb begin
    w_rden      = (r_state == L_LOAD) && (r_issue < r_len) && !src_fifo.src_fifo_empty;
    w_len_ok    = (ref_len_in != '0) && (ref_len_in <= DEPTH_L);
    w_load_acc  = load_start_in && (r_state == L_IDLE) && !r_shadow_valid && w_len_ok;
    w_abort     = abort_in && (r_state != L_IDLE);
    w_wr_en     = r_rd_valid && (r_state != L_IDLE) && !w_abort;
    w_last_wr   = w_wr_en && ((r_wr_ptr + ONE_L) == r_len);
    w_swap      = r_shadow_valid && !r_read_busy;
    w_start_acc = dtw_start_in && r_active_valid && !r_read_busy;
    w_mask_next = r_done_mask | dtw_done_in;
  end

  // load FSM: issue FIFO reads, then drain the one-cycle-late data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= L_IDLE;
      r_len      <= '0;
      r_issue    <= '0;
      r_wr_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_clear    <= 1'b0;
    end else begin
      r_clear    <= 1'b0;
      r_rd_valid <= w_rden;
      if (w_abort) begin
        r_state    <= L_IDLE;
        r_clear    <= 1'b1;
        r_rd_valid <= 1'b0;
      end else begin
        case (r_state)
          L_IDLE: begin
            if (w_load_acc) begin
              r_len    <= ref_len_in;
              r_issue  <= '0;
              r_wr_ptr <= '0;
              r_state  <= L_LOAD;
            end
          end
          L_LOAD: begin
            if (w_rden) begin
              r_issue <= r_issue + ONE_L;
              if ((r_issue + ONE_L) == r_len) r_state <= L_DRAIN;
            end
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + ONE_L;
          end
          L_DRAIN: begin
            if (w_wr_en)   r_wr_ptr <= r_wr_ptr + ONE_L;
            if (w_last_wr) r_state  <= L_IDLE;
          end
          default: r_state <= L_IDLE;
        endcase
      end
    end
  end

  // bank bookkeeping, swap, read session and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_valid <= 1'b0;
      r_shadow_len   <= '0;
      r_active_valid <= 1'b0;
      r_active_len   <= '0;
      r_active_bank  <= 1'b0;
      r_read_busy    <= 1'b0;
      r_done_mask    <= '0;
      r_err          <= 1'b0;
      r_rd_sel       <= 1'b0;
    end else begin
      if (w_swap) begin
        r_active_bank  <= ~r_active_bank;
        r_active_valid <= 1'b1;
        r_active_len   <= r_shadow_len;
        r_shadow_valid <= 1'b0;
      end else if (w_last_wr) begin
        r_shadow_valid <= 1'b1;
        r_shadow_len   <= r_len;
      end
      if (w_start_acc) begin
        r_read_busy <= 1'b1;
        r_done_mask <= '0;
      end else if (r_read_busy) begin
        r_done_mask <= w_mask_next;
        r_read_busy <= ~(&w_mask_next);
      end
      r_err    <= (load_start_in && !w_load_acc) || (dtw_start_in && !w_start_acc);
      r_rd_sel <= r_active_bank;
    end
  end

  dtw_ref_bank #(.WIDTH(WIDTH), .NUM_CORES(NUM_CORES), .PTR_W(REFMEM_PTR_WIDTH)) u_bank0 (
    .clk(clk), .rst_n(rst_n),
    .i_we(w_wr_en && r_active_bank), .i_waddr(r_wr_ptr[REFMEM_PTR_WIDTH-1:0]),
    .i_wdata(src_fifo.src_fifo_data_in), .i_raddr(dtw_read_addr_in), .o_rdata(w_rdata0)
  );

  dtw_ref_bank #(.WIDTH(WIDTH), .NUM_CORES(NUM_CORES), .PTR_W(REFMEM_PTR_WIDTH)) u_bank1 (
    .clk(clk), .rst_n(rst_n),
    .i_we(w_wr_en && !r_active_bank), .i_waddr(r_wr_ptr[REFMEM_PTR_WIDTH-1:0]),
    .i_wdata(src_fifo.src_fifo_data_in), .i_raddr(dtw_read_addr_in), .o_rdata(w_rdata1)
  );

  assign ref_data_out                = r_rd_sel ? w_rdata1 : w_rdata0;
  assign src_fifo.src_fifo_rden_out  = w_rden;
  assign src_fifo.src_fifo_clear_out = r_clear;
  assign load_busy_out               = (r_state != L_IDLE);
  assign read_busy_out               = r_read_busy;
  assign busy_out                    = load_busy_out | r_read_busy;
  assign active_valid_out            = r_active_valid;
  assign shadow_valid_out            = r_shadow_valid;
  assign active_bank_out             = r_active_bank;
  assign active_len_out              = r_active_len;
  assign err_out                     = r_err;
  assign dbg_load_state_out          = r_state;
  assign dbg_wr_addr_out             = r_wr_ptr[REFMEM_PTR_WIDTH-1:0];
endmodule
